// File: rtl/fight_ctrl.sv
// Battle controller for the fight scene: menu, skill selection, attack animations and
// tick-paced HP drain for both players, ending in a win/lose state.
module fight_ctrl #(
  parameter logic [7:0]  MAX_HP      = 8'd160,
  parameter logic [7:0]  DMG1        = 8'd20,
  parameter logic [7:0]  DMG2        = 8'd35,
  parameter logic [7:0]  DMG3        = 8'd50,
  parameter logic [7:0]  DMG4        = 8'd80,
  parameter logic [23:0] ANIM_CYCLES = 24'd12_500_000,
  parameter logic [23:0] TICK_CYCLES = 24'd1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_enter,
  output logic [5:0] fight_state,
  output logic [3:0] option_state,
  output logic [7:0] p1_cur_hp,
  output logic [7:0] p2_cur_hp,
  output logic       game_over,
  output logic       winner
);

  typedef enum logic [5:0] {
    StMenu    = 6'd1,
    StChoose  = 6'd2,
    StAnimP1  = 6'd3,
    StAnimP2  = 6'd4,
    StHpredP1 = 6'd5,
    StHpredP2 = 6'd6,
    StOver    = 6'd7
  } state_e;

  state_e      state_q, state_d;
  logic [23:0] timer_q, timer_d;
  logic [3:0]  option_q, option_d;
  logic [3:0]  ptr_q, ptr_d;
  logic [7:0]  p1_hp_q, p1_hp_d;
  logic [7:0]  p2_hp_q, p2_hp_d;
  logic [7:0]  p1_tgt_q, p1_tgt_d;
  logic [7:0]  p2_tgt_q, p2_tgt_d;
  logic        over_q, over_d;
  logic        winner_q, winner_d;

  function automatic logic [7:0] dmg_of(input logic [3:0] sel);
    logic [7:0] d;
    case (sel)
      4'd2:    d = DMG2;
      4'd3:    d = DMG3;
      4'd4:    d = DMG4;
      default: d = DMG1;
    endcase
    return d;
  endfunction

  function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? a - b : 8'd0;
  endfunction

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q + 24'd1;
    option_d = option_q;
    ptr_d    = ptr_q;
    p1_hp_d  = p1_hp_q;
    p2_hp_d  = p2_hp_q;
    p1_tgt_d = p1_tgt_q;
    p2_tgt_d = p2_tgt_q;
    winner_d = winner_q;

    case (state_q)
      StMenu: begin
        if (key_enter) state_d = StChoose;
      end
      StChoose: begin
        // Priority chain: only the highest-priority key pulse acts this cycle.
        if (key_enter) begin
          p2_tgt_d = sat_sub(p2_hp_q, dmg_of(option_q));
          state_d  = StAnimP1;
        end else if (key_up) begin
          if (option_q >= 4'd3) option_d = option_q - 4'd2;
        end else if (key_down) begin
          if (option_q <= 4'd2) option_d = option_q + 4'd2;
        end else if (key_left) begin
          if (option_q == 4'd2 || option_q == 4'd4) option_d = option_q - 4'd1;
        end else if (key_right) begin
          if (option_q == 4'd1 || option_q == 4'd3) option_d = option_q + 4'd1;
        end
      end
      StAnimP1: begin
        if (timer_q == ANIM_CYCLES - 24'd1) state_d = StHpredP2;
      end
      StHpredP2: begin
        if (p2_hp_q == p2_tgt_q) begin
          if (p2_hp_q == 8'd0) begin
            winner_d = 1'b0;
            state_d  = StOver;
          end else begin
            p1_tgt_d = sat_sub(p1_hp_q, dmg_of(ptr_q));
            state_d  = StAnimP2;
          end
        end else if (timer_q == TICK_CYCLES - 24'd1) begin
          timer_d = '0;
          if (p2_hp_q > p2_tgt_q) p2_hp_d = p2_hp_q - 8'd1;
        end
      end
      StAnimP2: begin
        if (timer_q == ANIM_CYCLES - 24'd1) begin
          ptr_d   = (ptr_q == 4'd4) ? 4'd1 : ptr_q + 4'd1;
          state_d = StHpredP1;
        end
      end
      StHpredP1: begin
        if (p1_hp_q == p1_tgt_q) begin
          if (p1_hp_q == 8'd0) begin
            winner_d = 1'b1;
            state_d  = StOver;
          end else begin
            state_d = StChoose;
          end
        end else if (timer_q == TICK_CYCLES - 24'd1) begin
          timer_d = '0;
          if (p1_hp_q > p1_tgt_q) p1_hp_d = p1_hp_q - 8'd1;
        end
      end
      StOver: begin
        if (key_enter) begin
          p1_hp_d  = MAX_HP;
          p2_hp_d  = MAX_HP;
          p1_tgt_d = MAX_HP;
          p2_tgt_d = MAX_HP;
          option_d = 4'd1;
          ptr_d    = 4'd1;
          state_d  = StMenu;
        end
      end
      default: state_d = StMenu;
    endcase

    if (state_d != state_q) timer_d = '0;
    over_d = (state_d == StOver);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StMenu;
      timer_q  <= '0;
      option_q <= 4'd1;
      ptr_q    <= 4'd1;
      p1_hp_q  <= MAX_HP;
      p2_hp_q  <= MAX_HP;
      p1_tgt_q <= MAX_HP;
      p2_tgt_q <= MAX_HP;
      over_q   <= 1'b0;
      winner_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      option_q <= option_d;
      ptr_q    <= ptr_d;
      p1_hp_q  <= p1_hp_d;
      p2_hp_q  <= p2_hp_d;
      p1_tgt_q <= p1_tgt_d;
      p2_tgt_q <= p2_tgt_d;
      over_q   <= over_d;
      winner_q <= winner_d;
    end
  end

  assign fight_state  = state_q;
  assign option_state = option_q;
  assign p1_cur_hp    = p1_hp_q;
  assign p2_cur_hp    = p2_hp_q;
  assign game_over    = over_q;
  assign winner       = winner_q;

endmodule

// File: tb/tb_fight_ctrl.sv
// Randomized self-checking bench for fight_ctrl against a turn-level battle model.
module tb_fight_ctrl;

  logic       clk;
  logic       rst_n;
  logic       key_up, key_down, key_left, key_right, key_enter;
  logic [5:0] fight_state;
  logic [3:0] option_state;
  logic [7:0] p1_cur_hp, p2_cur_hp;
  logic       game_over, winner;

  int n_vec;
  int n_err;

  // Battle model: option cursor, HP of both players, P2 skill pointer, game-over flag.
  int m_opt, m_p1, m_p2, m_ptr;
  bit m_over;
  int dmg_tab[4] = '{5, 10, 15, 20};

  localparam int MaxHp = 20;
  localparam int Anim  = 8;
  localparam int Tick  = 4;

  fight_ctrl #(
    .MAX_HP     (8'd20),
    .DMG1       (8'd5),
    .DMG2       (8'd10),
    .DMG3       (8'd15),
    .DMG4       (8'd20),
    .ANIM_CYCLES(24'd8),
    .TICK_CYCLES(24'd4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_up      (key_up),
    .key_down    (key_down),
    .key_left    (key_left),
    .key_right   (key_right),
    .key_enter   (key_enter),
    .fight_state (fight_state),
    .option_state(option_state),
    .p1_cur_hp   (p1_cur_hp),
    .p2_cur_hp   (p2_cur_hp),
    .game_over   (game_over),
    .winner      (winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sat(input int a, input int b);
    return (a > b) ? a - b : 0;
  endfunction

  // Cursor on a 2x2 grid: up/down pick the row, left/right pick the column.
  // keys: [3]=up [2]=down [1]=left [0]=right, highest bit wins.
  function automatic int grid_move(input int opt, input logic [3:0] k);
    int row;
    int col;
    row = (opt - 1) / 2;
    col = (opt - 1) % 2;
    if (k[3])      row = 0;
    else if (k[2]) row = 1;
    else if (k[1]) col = 0;
    else if (k[0]) col = 1;
    return row * 2 + col + 1;
  endfunction

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // keys: [4]=enter [3]=up [2]=down [1]=left [0]=right, held for one clock edge.
  task automatic press(input logic [4:0] keys);
    {key_enter, key_up, key_down, key_left, key_right} = keys;
    step(1);
    {key_enter, key_up, key_down, key_left, key_right} = '0;
  endtask

  task automatic model_reset();
    m_opt  = 1;
    m_p1   = MaxHp;
    m_p2   = MaxHp;
    m_ptr  = 1;
    m_over = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    {key_enter, key_up, key_down, key_left, key_right} = '0;
    step(2);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic go_to(input int target);
    logic [3:0] k;
    for (int i = 0; i < 4; i++) begin
      if (m_opt != target) begin
        if ((target - 1) / 2 < (m_opt - 1) / 2)      k = 4'b1000;
        else if ((target - 1) / 2 > (m_opt - 1) / 2) k = 4'b0100;
        else if (target < m_opt)                     k = 4'b0010;
        else                                         k = 4'b0001;
        press({1'b0, k});
        m_opt = grid_move(m_opt, k);
        n_vec++;
        if (option_state !== 4'(m_opt)) begin
          n_err++;
          $display("FAIL go_to: option=%0d want %0d", option_state, m_opt);
        end
      end
    end
  endtask

  // One full round from CHOOSE: P1 attack, P2 drain, P2 attack, P1 drain.
  task automatic run_turn(input logic [4:0] keys);
    int o, np, dr;
    o  = m_opt;
    np = sat(m_p2, dmg_tab[o-1]);
    dr = m_p2 - np;
    press(keys);
    n_vec++;
    if (fight_state !== 6'd3 || option_state !== 4'(o)) begin
      n_err++;
      $display("FAIL turn_start: state=%0d opt=%0d want 3/%0d", fight_state, option_state, o);
    end
    for (int i = 0; i < Anim - 1; i++) begin
      press(5'($urandom_range(0, 31)));
      n_vec++;
      if (fight_state !== 6'd3 || option_state !== 4'(o)) begin
        n_err++;
        $display("FAIL anim_p1_hold: state=%0d opt=%0d want 3/%0d", fight_state, option_state, o);
      end
    end
    step(1);
    n_vec++;
    if (fight_state !== 6'd6 || p2_cur_hp !== 8'(m_p2)) begin
      n_err++;
      $display("FAIL hpred_p2_entry: state=%0d p2=%0d want 6/%0d", fight_state, p2_cur_hp, m_p2);
    end
    step(Tick);
    n_vec++;
    if (p2_cur_hp !== 8'(m_p2 - 1)) begin
      n_err++;
      $display("FAIL p2_first_tick: p2=%0d want %0d", p2_cur_hp, m_p2 - 1);
    end
    step(dr * Tick - Tick);
    n_vec++;
    if (fight_state !== 6'd6 || p2_cur_hp !== 8'(np)) begin
      n_err++;
      $display("FAIL p2_drained: state=%0d p2=%0d want 6/%0d", fight_state, p2_cur_hp, np);
    end
    step(1);
    m_p2 = np;
    if (np == 0) begin
      m_over = 1;
      n_vec++;
      if (fight_state !== 6'd7 || game_over !== 1'b1 || winner !== 1'b0) begin
        n_err++;
        $display("FAIL p1_wins: state=%0d go=%0d win=%0d want 7/1/0",
                 fight_state, game_over, winner);
      end
      return;
    end
    n_vec++;
    if (fight_state !== 6'd4) begin
      n_err++;
      $display("FAIL anim_p2_entry: state=%0d want 4", fight_state);
    end
    step(Anim);
    n_vec++;
    if (fight_state !== 6'd5 || p1_cur_hp !== 8'(m_p1)) begin
      n_err++;
      $display("FAIL hpred_p1_entry: state=%0d p1=%0d want 5/%0d", fight_state, p1_cur_hp, m_p1);
    end
    np = sat(m_p1, dmg_tab[m_ptr-1]);
    dr = m_p1 - np;
    step(dr * Tick);
    n_vec++;
    if (fight_state !== 6'd5 || p1_cur_hp !== 8'(np)) begin
      n_err++;
      $display("FAIL p1_drained: state=%0d p1=%0d want 5/%0d", fight_state, p1_cur_hp, np);
    end
    step(1);
    m_p1  = np;
    m_ptr = m_ptr % 4 + 1;
    n_vec++;
    if (np == 0) begin
      m_over = 1;
      if (fight_state !== 6'd7 || game_over !== 1'b1 || winner !== 1'b1) begin
        n_err++;
        $display("FAIL p2_wins: state=%0d go=%0d win=%0d want 7/1/1",
                 fight_state, game_over, winner);
      end
    end else if (fight_state !== 6'd2 || option_state !== 4'(o)) begin
      n_err++;
      $display("FAIL back_to_choose: state=%0d opt=%0d want 2/%0d", fight_state, option_state, o);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    {key_enter, key_up, key_down, key_left, key_right} = '0;
    step(2);
    n_vec++;
    if (fight_state !== 6'd1 || option_state !== 4'd1 || p1_cur_hp !== 8'd20 ||
        p2_cur_hp !== 8'd20 || game_over !== 1'b0 || winner !== 1'b0) begin
      n_err++;
      $display("FAIL reset: st=%0d opt=%0d p1=%0d p2=%0d go=%0d win=%0d want 1/1/20/20/0/0",
               fight_state, option_state, p1_cur_hp, p2_cur_hp, game_over, winner);
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_menu_nav();
    logic [3:0] k;
    for (int i = 0; i < 5; i++) begin
      press({1'b0, 4'($urandom_range(1, 15))});
      n_vec++;
      if (fight_state !== 6'd1 || option_state !== 4'd1) begin
        n_err++;
        $display("FAIL menu_ignore: state=%0d opt=%0d want 1/1", fight_state, option_state);
      end
    end
    press(5'b10000);
    n_vec++;
    if (fight_state !== 6'd2) begin
      n_err++;
      $display("FAIL menu_enter: state=%0d want 2", fight_state);
    end
    // right, down, left, up, then up and left at the corner
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: k = 4'b0001;
        1: k = 4'b0100;
        2: k = 4'b0010;
        3: k = 4'b1000;
        4: k = 4'b1000;
        default: k = 4'b0010;
      endcase
      press({1'b0, k});
      m_opt = grid_move(m_opt, k);
      n_vec++;
      if (option_state !== 4'(m_opt)) begin
        n_err++;
        $display("FAIL grid_fixed: option=%0d want %0d", option_state, m_opt);
      end
    end
    for (int i = 0; i < 30; i++) begin
      k = 4'($urandom_range(1, 15));
      press({1'b0, k});
      m_opt = grid_move(m_opt, k);
      n_vec++;
      if (fight_state !== 6'd2 || option_state !== 4'(m_opt)) begin
        n_err++;
        $display("FAIL grid_random: state=%0d opt=%0d want 2/%0d", fight_state, option_state, m_opt);
      end
    end
  endtask

  task automatic test_turn();
    go_to(2);
    run_turn(5'b10000);
  endtask

  task automatic test_priority();
    run_turn(5'b11001);
  endtask

  task automatic test_p1_win();
    do_reset();
    press(5'b10000);
    go_to(4);
    run_turn(5'b10000);
    press(5'b10000);
    model_reset();
    n_vec++;
    if (fight_state !== 6'd1 || p1_cur_hp !== 8'd20 || p2_cur_hp !== 8'd20 ||
        option_state !== 4'd1 || game_over !== 1'b0) begin
      n_err++;
      $display("FAIL over_to_menu: st=%0d p1=%0d p2=%0d opt=%0d go=%0d want 1/20/20/1/0",
               fight_state, p1_cur_hp, p2_cur_hp, option_state, game_over);
    end
  endtask

  task automatic test_p2_win();
    do_reset();
    press(5'b10000);
    for (int t = 0; t < 8; t++) begin
      if (!m_over) begin
        go_to(1);
        run_turn(5'b10000);
      end
    end
    n_vec++;
    if (!m_over || winner !== 1'b1 || p1_cur_hp !== 8'd0 || game_over !== 1'b1) begin
      n_err++;
      $display("FAIL p2_win_end: over=%0d win=%0d p1=%0d go=%0d want 1/1/0/1",
               m_over, winner, p1_cur_hp, game_over);
    end
  endtask

  task automatic test_random_battles();
    for (int g = 0; g < 3; g++) begin
      do_reset();
      press(5'b10000);
      for (int t = 0; t < 20; t++) begin
        if (!m_over) begin
          go_to($urandom_range(1, 4));
          run_turn({1'b1, 4'($urandom_range(0, 15))});
        end
      end
      press(5'b10000);
      model_reset();
      n_vec++;
      if (fight_state !== 6'd1 || p1_cur_hp !== 8'd20 || p2_cur_hp !== 8'd20) begin
        n_err++;
        $display("FAIL random_game_end: st=%0d p1=%0d p2=%0d want 1/20/20",
                 fight_state, p1_cur_hp, p2_cur_hp);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    press(5'b10000);
    go_to(2);
    press(5'b10000);
    step(Anim + 6 * Tick);
    n_vec++;
    if (fight_state !== 6'd6 || p2_cur_hp !== 8'd14) begin
      n_err++;
      $display("FAIL mid_drain: state=%0d p2=%0d want 6/14", fight_state, p2_cur_hp);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (fight_state !== 6'd1 || option_state !== 4'd1 || p1_cur_hp !== 8'd20 ||
        p2_cur_hp !== 8'd20 || game_over !== 1'b0 || winner !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: st=%0d opt=%0d p1=%0d p2=%0d go=%0d win=%0d want 1/1/20/20/0/0",
               fight_state, option_state, p1_cur_hp, p2_cur_hp, game_over, winner);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    {key_enter, key_up, key_down, key_left, key_right} = '0;
    model_reset();
    test_reset();
    test_menu_nav();
    test_turn();
    test_priority();
    test_p1_win();
    test_p2_win();
    test_random_battles();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
